draw_sequencer: RTL and testbench
=================================

# draw_sequencer

Parametrised draw-pass sequencer for the space-shooter renderer. On each frame trigger it walks a configurable number of sprite slots (player, enemies, bullets) and issues one draw request per active slot to the shared pixel drawer, waiting for the drawer's `done` before moving on. Inactive slots are skipped. An optional erase pass, which redraws every active slot in background colour, runs before the draw pass. The block sits between the game-state logic, which supplies the active mask and the frame tick, and the sprite drawer, which consumes `obj_idx`, `draw_req` and `erase_mode`.

## Interface
- `NUM_OBJ`, default 6: number of sprite slots, legal range 1..(2^IDX_W − 1).
- `IDX_W`, default 4: width of the slot index; must satisfy 2^IDX_W > NUM_OBJ.
- `clk` input 1: the single clock; all state is updated on its rising edge.
- `resetn` input 1: reset, asynchronous and active-low.
- `frame_start` input 1: one-cycle pulse that starts a frame; sampled only in IDLE.
- `obj_active` input NUM_OBJ: per-slot enable; bit i high means slot i is drawn. Latched at frame start.
- `erase_en` input 1: when high, an erase pass precedes the draw pass. Latched at frame start.
- `done` input 1: drawer finished the current request; sampled only in WAIT.
- `obj_idx` output IDX_W: slot currently being serviced; valid in REQ and WAIT.
- `draw_req` output 1: one-cycle start pulse to the drawer.
- `erase_mode` output 1: 1 during the erase pass, 0 during the draw pass.
- `busy` output 1: high in every state except IDLE.
- `frame_done` output 1: one-cycle pulse when the frame is complete.

## Operation
- States: IDLE, SCAN, REQ, WAIT, FINISH. All outputs are registered or decoded from registered state.
- IDLE:
  - On `frame_start`=1, latch `obj_active` into `mask_q`, set `idx`=0, set `pass` = erase if `erase_en` else draw, and go to SCAN.
  - Otherwise stay in IDLE.
- SCAN, evaluated once per cycle:
  - `idx`==NUM_OBJ and `pass`==erase: set `pass`=draw, set `idx`=0, stay in SCAN.
  - `idx`==NUM_OBJ and `pass`==draw: go to FINISH.
  - `mask_q[idx]`=1: go to REQ.
  - Otherwise: `idx`+1, stay in SCAN.
- REQ: `draw_req`=1 for exactly this cycle, then go to WAIT unconditionally.
- WAIT: hold `obj_idx`. On `done`=1, `idx`+1 and go to SCAN.
- FINISH: `frame_done`=1 for this cycle, then go to IDLE.
- `erase_mode` follows `pass`. It is 1 only while the erase pass is in SCAN, REQ or WAIT, and 0 otherwise, including in IDLE and FINISH.
- Width rule: `idx` is IDX_W bits and counts 0..NUM_OBJ inclusive. It never wraps, because the IDX_W constraint guarantees NUM_OBJ is representable.
- Boundary conditions:
  - All-zero mask: no `draw_req` is issued; the frame still completes and pulses `frame_done`.
  - `frame_start` while `busy`=1, including in FINISH: ignored, not queued.
  - `obj_active` or `erase_en` changing mid-frame: no effect until the next frame.
  - `done` in IDLE, SCAN, REQ or FINISH: ignored. A drawer may not complete in zero cycles.
  - `done` held high continuously: each WAIT lasts one cycle. Slot service then takes REQ + WAIT + SCAN = 3 cycles.
  - `frame_start` and `done` high together in IDLE: the frame starts and `done` is ignored.
- Reset, asserted at any time including mid-frame:
  - State goes to IDLE immediately and asynchronously; `idx`, `mask_q` and `pass` are cleared.
  - `obj_idx`=0, `draw_req`=0, `erase_mode`=0, `busy`=0, `frame_done`=0.
  - No `frame_done` is issued for the aborted frame.

## Timing
- Edge E0 samples `frame_start`=1. SCAN starts the cycle after E0, and `busy` rises in that same cycle.
- Each inactive slot costs 1 SCAN cycle.
- Each active slot costs 1 SCAN + 1 REQ + N WAIT cycles, where N≥1 is the number of cycles until `done`.
- End-of-pass check costs 1 SCAN cycle; the erase-to-draw switch costs that same cycle.
- Empty mask, `erase_en`=0: SCAN for NUM_OBJ+1 cycles, then FINISH. `frame_done` is high in cycle NUM_OBJ+2 after E0.
- Empty mask, `erase_en`=1: 2·(NUM_OBJ+1) SCAN cycles, then FINISH.
- `draw_req` is never high in two consecutive cycles.
- `obj_idx` is stable from REQ through the cycle in which `done` is sampled.
- `busy` falls in the cycle after FINISH.

## Test plan
- Reset and idle behaviour:
  - Stimulus: assert `resetn`=0 asynchronously between clock edges, then release; pulse nothing.
  - Response: all outputs are 0 immediately on reset assertion; state stays in IDLE with no `draw_req`.
- Full draw pass:
  - Stimulus: NUM_OBJ=6, `obj_active`=6'b111111, `erase_en`=0, drawer returns `done` 3 cycles after each `draw_req`.
  - Response: exactly 6 `draw_req` pulses with `obj_idx` 0,1,2,3,4,5; `erase_mode`=0 throughout; then one `frame_done`.
- Sparse mask with erase:
  - Stimulus: `obj_active`=6'b100101, `erase_en`=1.
  - Response: `draw_req` with `obj_idx` 0,2,5 and `erase_mode`=1, then 0,2,5 with `erase_mode`=0, then `frame_done`.
- Empty mask latency:
  - Stimulus: `obj_active`=0, `erase_en`=0.
  - Response: no `draw_req`; `frame_done` high exactly 8 cycles after the E0 edge.
- Ignored inputs:
  - Stimulus: pulse `frame_start` and change `obj_active` during WAIT; pulse `done` during REQ.
  - Response: the running sequence is unchanged and no second frame starts; with one `frame_done` and no further `draw_req`, `busy` falls in the cycle after FINISH.
- Reset mid-frame:
  - Stimulus: assert `resetn`=0 while in WAIT at `obj_idx`=3, release, then issue a new `frame_start`.
  - Response: all outputs clear immediately and no `frame_done` is issued for the aborted frame; the new frame restarts at `obj_idx`=0.

Source files
------------

// File: rtl/draw_sequencer.sv
// rtl/draw_sequencer.sv - per-frame erase/draw pass sequencer feeding the shared sprite drawer
module draw_sequencer #(
    parameter int NUM_OBJ = 6,
    parameter int IDX_W   = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               frame_start,
    input  logic [NUM_OBJ-1:0] obj_active,
    input  logic               erase_en,
    input  logic               done,
    output logic [IDX_W-1:0]   obj_idx,
    output logic               draw_req,
    output logic               erase_mode,
    output logic               busy,
    output logic               frame_done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SCAN   = 3'd1;
    localparam logic [2:0] S_REQ    = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ);

    logic [2:0]               state;
    logic [IDX_W-1:0]         idx;
    logic [NUM_OBJ-1:0]       mask_q;
    logic                     pass_erase;
    logic [(1<<IDX_W)-1:0]    mask_ext;

    // Zero-extend so idx == NUM_OBJ indexes a defined bit; that case is handled before the lookup.
    always_comb begin
        mask_ext = '0;
        mask_ext[NUM_OBJ-1:0] = mask_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            idx        <= '0;
            mask_q     <= '0;
            pass_erase <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        mask_q     <= obj_active;
                        idx        <= '0;
                        pass_erase <= erase_en;
                        state      <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (idx == LAST_IDX) begin
                        if (pass_erase) begin
                            pass_erase <= 1'b0;
                            idx        <= '0;
                        end else begin
                            idx   <= '0;
                            state <= S_FINISH;
                        end
                    end else if (mask_ext[idx]) begin
                        state <= S_REQ;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_REQ: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (done) begin
                        idx   <= idx + 1'b1;
                        state <= S_SCAN;
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign obj_idx    = idx;
    assign draw_req   = (state == S_REQ);
    assign busy       = (state != S_IDLE);
    assign frame_done = (state == S_FINISH);
    assign erase_mode = pass_erase &&
                        ((state == S_SCAN) || (state == S_REQ) || (state == S_WAIT));

endmodule

// File: tb/tb_draw_sequencer.sv
// tb/tb_draw_sequencer.sv - scoreboard bench for draw_sequencer with a randomized drawer model
module tb_draw_sequencer;

    localparam int NUM_OBJ = 6;
    localparam int IDX_W   = 4;

    logic               clk;
    logic               resetn;
    logic               frame_start;
    logic [NUM_OBJ-1:0] obj_active;
    logic               erase_en;
    logic               done;
    logic [IDX_W-1:0]   obj_idx;
    logic               draw_req;
    logic               erase_mode;
    logic               busy;
    logic               frame_done;

    draw_sequencer #(.NUM_OBJ(NUM_OBJ), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .frame_start(frame_start),
        .obj_active (obj_active),
        .erase_en   (erase_en),
        .done       (done),
        .obj_idx    (obj_idx),
        .draw_req   (draw_req),
        .erase_mode (erase_mode),
        .busy       (busy),
        .frame_done (frame_done)
    );

    typedef struct {
        bit fin;
        int idx;
        bit ers;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   fixed_lat = 3;
    bit   hold_done = 0;
    bit   inject_req_done = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Reference: every active slot is drawn in ascending order, once per pass, erase pass first.
    task automatic push_model(input logic [NUM_OBJ-1:0] m, input bit er);
        exp_t e;
        for (int p = (er ? 1 : 0); p >= 0; p--) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                if (m[i]) begin
                    e.fin = 0; e.idx = i; e.ers = bit'(p);
                    exp_q.push_back(e);
                end
            end
        end
        e.fin = 1; e.idx = 0; e.ers = 0;
        exp_q.push_back(e);
    endtask

    function automatic int pred_cycles(input logic [NUM_OBJ-1:0] m, input bit er, input int n);
        int passes;
        passes = er ? 2 : 1;
        return 1 + passes * (NUM_OBJ + 1) + passes * $countones(m) * (1 + n);
    endfunction

    // Drawer model: done arrives N cycles after each draw_req, N fixed or random.
    initial begin
        int cnt;
        cnt  = 0;
        done = 1'b0;
        forever begin
            @(negedge clk);
            done = hold_done;
            if (!resetn) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) done = 1'b1;
                end
                if (draw_req) begin
                    cnt = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
                    if (inject_req_done) done = 1'b1;
                end
            end
        end
    end

    // Monitor: pops expectations on every draw_req / frame_done and watches obj_idx through WAIT.
    initial begin
        bit   prev_req;
        bit   waiting;
        int   req_idx;
        exp_t e;
        prev_req = 0;
        waiting  = 0;
        req_idx  = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_req = 0;
                waiting  = 0;
            end else begin
                if (draw_req) begin
                    check("req_not_consecutive", int'(prev_req), 0);
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_draw_req");
                    end else begin
                        e = exp_q.pop_front();
                        check("req_not_frame_end", int'(e.fin), 0);
                        check("req_obj_idx", int'(obj_idx), e.idx);
                        check("req_erase_mode", int'(erase_mode), int'(e.ers));
                    end
                    req_idx = int'(obj_idx);
                    waiting = 1;
                end else if (waiting) begin
                    check("wait_obj_idx_stable", int'(obj_idx), req_idx);
                    if (done) waiting = 0;
                end
                if (frame_done) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_frame_done");
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_done_order", int'(e.fin), 1);
                    end
                    check("finish_erase_mode", int'(erase_mode), 0);
                end
                prev_req = draw_req;
            end
        end
    end

    task automatic start_frame(input logic [NUM_OBJ-1:0] m, input bit er);
        push_model(m, er);
        @(negedge clk);
        obj_active  = m;
        erase_en    = er;
        frame_start = 1'b1;
        @(posedge clk);
        #1 frame_start = 1'b0;
    endtask

    task automatic wait_frame(input int exp_cycles, input string name);
        int cyc;
        bit got;
        cyc = 0;
        got = 0;
        while (!got && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check({name, "_busy_rise"}, int'(busy), 1);
            if (frame_done) got = 1;
        end
        if (!got) begin
            fail_now({name, "_frame_done_timeout"});
        end else begin
            if (exp_cycles > 0) check({name, "_latency"}, cyc, exp_cycles);
            @(negedge clk);
            check({name, "_busy_fall"}, int'(busy), 0);
            check({name, "_queue_drained"}, exp_q.size(), 0);
        end
    endtask

    task automatic check_quiet(input int n, input string name);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            seen += int'(draw_req) + int'(busy) + int'(frame_done);
        end
        check(name, seen, 0);
    endtask

    task automatic check_outputs_clear(input string name);
        check({name, "_obj_idx"},    int'(obj_idx), 0);
        check({name, "_draw_req"},   int'(draw_req), 0);
        check({name, "_erase_mode"}, int'(erase_mode), 0);
        check({name, "_busy"},       int'(busy), 0);
        check({name, "_frame_done"}, int'(frame_done), 0);
    endtask

    initial begin
        logic [NUM_OBJ-1:0] m;
        bit er;
        int lat;
        int waited;

        resetn      = 1'b0;
        frame_start = 1'b0;
        obj_active  = '0;
        erase_en    = 1'b0;
        #1;
        check_outputs_clear("reset");
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        check_quiet(5, "idle_quiet");

        #2 resetn = 1'b0;
        #1 check_outputs_clear("async_reset_idle");
        @(negedge clk);
        resetn = 1'b1;

        fixed_lat = 3;
        start_frame(6'b111111, 1'b0);
        wait_frame(pred_cycles(6'b111111, 1'b0, 3), "full_pass");

        start_frame(6'b100101, 1'b1);
        wait_frame(pred_cycles(6'b100101, 1'b1, 3), "sparse_erase");

        start_frame(6'b000000, 1'b0);
        wait_frame(8, "empty_mask");

        start_frame(6'b000000, 1'b1);
        wait_frame(2 * (NUM_OBJ + 1) + 1, "empty_mask_erase");

        hold_done = 1;
        start_frame(6'b011011, 1'b1);
        wait_frame(pred_cycles(6'b011011, 1'b1, 1), "done_held");
        hold_done = 0;

        fixed_lat       = 3;
        inject_req_done = 1;
        fork
            begin
                start_frame(6'b110110, 1'b0);
                wait_frame(pred_cycles(6'b110110, 1'b0, 3), "ignored_inputs");
            end
            begin
                waited = 0;
                @(negedge clk);
                while (!draw_req && waited < 50) begin
                    @(negedge clk);
                    waited++;
                end
                if (!draw_req) fail_now("ignored_inputs_no_req");
                @(negedge clk);
                frame_start = 1'b1;
                obj_active  = 6'b001001;
                erase_en    = 1'b1;
                @(negedge clk);
                frame_start = 1'b0;
            end
        join
        inject_req_done = 0;
        check_quiet(12, "no_second_frame");

        fixed_lat = 3;
        start_frame(6'b111111, 1'b0);
        waited = 0;
        while (!(draw_req && obj_idx == 4'd3) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!(draw_req && obj_idx == 4'd3)) fail_now("midframe_no_req3");
        @(negedge clk);
        #2 resetn = 1'b0;
        #1 check_outputs_clear("midframe_reset");
        exp_q.delete();
        @(negedge clk);
        resetn = 1'b1;
        check_quiet(12, "aborted_frame_silent");
        start_frame(6'b111111, 1'b0);
        wait_frame(pred_cycles(6'b111111, 1'b0, 3), "restart_after_reset");

        for (int f = 0; f < 20; f++) begin
            m         = NUM_OBJ'($urandom);
            er        = bit'($urandom_range(0, 1));
            lat       = int'($urandom_range(0, 4));
            fixed_lat = lat;
            start_frame(m, er);
            wait_frame((lat > 0) ? pred_cycles(m, er, lat) : 0, "random_frame");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
